// File: rtl/gemm_psum_accumulator.sv
// Accumulates TILES adder-tree partial sums into one dot product, requantizes it
// to 8 bits with shift+saturate, and queues results in a small FWFT FIFO.
module gemm_psum_accumulator #(
    parameter int unsigned TILES      = 4,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             psum_valid,
    output logic             psum_ready,
    input  logic [17:0]      psum_data,
    input  logic [4:0]       shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [7:0]       out_q,
    output logic             out_sat
);

    localparam int unsigned CNT_W   = $clog2(TILES);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W  = PTR_W + 1;
    localparam int unsigned OCC_W   = FCNT_W + 1;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned Q_W     = 8;

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic [Q_W-1:0]   q;
        logic             sat;
    } result_t;

    logic [CNT_W-1:0]   tile_cnt;
    logic [ACC_W-1:0]   acc;
    logic [SHIFT_W-1:0] shift_r;
    logic               s1_valid;
    logic [ACC_W-1:0]   s1_sum;
    logic [SHIFT_W-1:0] s1_shift;

    result_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [FCNT_W-1:0]  fifo_count;

    logic               last_tile_c;
    logic               accept_c;
    logic               push_c;
    logic               pop_c;
    logic [ACC_W-1:0]   psum_ext_c;
    logic [ACC_W-1:0]   sum_c;
    logic [OCC_W-1:0]   occupancy_c;
    logic [ACC_W-1:0]   q_full_c;
    result_t            wr_data_c;
    result_t            head_c;

    // Ready depends only on registered occupancy, never on out_ready.
    assign last_tile_c = (tile_cnt == CNT_W'(TILES - 1));
    assign occupancy_c = OCC_W'(fifo_count) + OCC_W'(s1_valid);
    assign psum_ready  = rst_n && (!last_tile_c || (occupancy_c < OCC_W'(FIFO_DEPTH)));
    assign accept_c    = psum_valid && psum_ready;
    assign psum_ext_c  = ACC_W'(psum_data);
    assign sum_c       = (tile_cnt == '0) ? psum_ext_c : acc + psum_ext_c;

    // Tile counter, running sum and per-group shift capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tile_cnt <= '0;
            acc      <= '0;
            shift_r  <= '0;
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_shift <= '0;
        end else begin
            s1_valid <= accept_c && last_tile_c;
            if (accept_c) begin
                acc      <= sum_c;
                tile_cnt <= last_tile_c ? '0 : tile_cnt + CNT_W'(1);
                if (tile_cnt == '0) begin
                    shift_r <= shift;
                end
                if (last_tile_c) begin
                    s1_sum   <= sum_c;
                    s1_shift <= shift_r;
                end
            end
        end
    end

    // Requantize the S1 result: right shift, clip to 255.
    always_comb begin
        wr_data_c     = '0;
        q_full_c      = s1_sum >> s1_shift;
        wr_data_c.acc = s1_sum;
        wr_data_c.sat = |q_full_c[ACC_W-1:Q_W];
        wr_data_c.q   = wr_data_c.sat ? '1 : q_full_c[Q_W-1:0];
    end

    assign push_c = s1_valid;
    assign pop_c  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Head fields read as zero while the FIFO is empty.
    assign out_valid = (fifo_count != '0);
    assign head_c    = out_valid ? mem[rd_ptr] : '0;
    assign out_acc   = head_c.acc;
    assign out_q     = head_c.q;
    assign out_sat   = head_c.sat;

endmodule

// File: tb/tb_gemm_psum_accumulator.sv
// Self-checking bench for gemm_psum_accumulator: directed cases plus random traffic
// checked against a queue-based reference model of groups, latency and occupancy.
module tb_gemm_psum_accumulator;

    localparam int unsigned TILES = 4;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             psum_valid;
    logic             psum_ready;
    logic [17:0]      psum_data;
    logic [4:0]       shift;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [7:0]       out_q;
    logic             out_sat;

    always #5 clk = ~clk;

    gemm_psum_accumulator #(
        .TILES(TILES), .ACC_W(ACC_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .psum_valid(psum_valid), .psum_ready(psum_ready),
        .psum_data(psum_data), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_q(out_q), .out_sat(out_sat)
    );

    typedef struct {
        longint unsigned acc;
        longint unsigned q;
        longint unsigned sat;
        int              rc;
    } exp_t;

    exp_t            exp_q[$];
    int              errors = 0;
    int              checks = 0;
    int              cyc    = 0;
    int              m_cnt  = 0;
    longint unsigned m_sum  = 0;
    int unsigned     m_shift = 0;
    bit              accepted;
    int              pops = 0;
    int              ready_drops = 0;
    int              last_accept_cyc = 0;
    int              last_pop_cyc = 0;
    logic [63:0]     last_acc, last_q, last_sat;
    int              pops0, drops0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference model: sampled mid-cycle with the inputs applied for this cycle.
    task automatic eval();
        bit exp_ready, exp_valid;
        longint unsigned qf;
        exp_t e;
        accepted = 1'b0;
        if (!rst_n) begin
            chk("rst_psum_ready", psum_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_acc", out_acc, 0);
            chk("rst_out_q", out_q, 0);
            chk("rst_out_sat", out_sat, 0);
            m_cnt = 0;
            exp_q.delete();
            cyc++;
            return;
        end
        exp_ready = (m_cnt != TILES - 1) || (exp_q.size() < DEPTH);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].rc <= cyc);
        chk("psum_ready", psum_ready, 64'(exp_ready));
        chk("out_valid", out_valid, 64'(exp_valid));
        if (!psum_ready) ready_drops++;
        if (exp_valid) begin
            chk("out_acc", out_acc, exp_q[0].acc);
            chk("out_q", out_q, exp_q[0].q);
            chk("out_sat", out_sat, exp_q[0].sat);
            if (out_ready) begin
                last_acc = 64'(out_acc);
                last_q = 64'(out_q);
                last_sat = 64'(out_sat);
                last_pop_cyc = cyc;
                void'(exp_q.pop_front());
                pops++;
            end
        end
        if (psum_valid && exp_ready) begin
            accepted = 1'b1;
            last_accept_cyc = cyc;
            if (m_cnt == 0) begin
                m_sum = 64'(psum_data);
                m_shift = 32'(shift);
            end else begin
                m_sum += 64'(psum_data);
            end
            m_cnt++;
            if (m_cnt == TILES) begin
                qf = m_sum >> m_shift;
                e.acc = m_sum;
                e.sat = (qf > 255) ? 1 : 0;
                e.q = (qf > 255) ? 255 : qf;
                e.rc = cyc + 2;
                exp_q.push_back(e);
                m_cnt = 0;
            end
        end
        cyc++;
    endtask

    task automatic step(input bit r, input bit v, input logic [17:0] d,
                        input logic [4:0] sh, input bit ordy);
        rst_n = r; psum_valid = v; psum_data = d; shift = sh; out_ready = ordy;
        #1;
        eval();
        @(negedge clk);
    endtask

    task automatic send(input logic [17:0] d, input logic [4:0] sh, input bit ordy);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b1, d, sh, ordy);
            if (accepted) return;
        end
        chk("send_timeout", 64'(accepted), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
            step(1'b1, 1'b0, 18'd0, 5'd0, 1'b1);
        end
        chk("drain_empty", 64'(exp_q.size()), 0);
        step(1'b1, 1'b0, 18'd0, 5'd0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; psum_valid = 1'b0; psum_data = '0; shift = '0; out_ready = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0, 18'd0, 5'd0, 1'b0);
        step(1'b0, 1'b1, 18'd5, 5'd0, 1'b1);

        // Small sum, no shift: saturates; also checks two-cycle latency.
        send(18'd100, 5'd0, 1'b1); send(18'd200, 5'd0, 1'b1);
        send(18'd300, 5'd0, 1'b1); send(18'd400, 5'd0, 1'b1);
        drain();
        chk("t1_acc", last_acc, 1000);
        chk("t1_q", last_q, 255);
        chk("t1_sat", last_sat, 1);
        chk("t1_latency", 64'(last_pop_cyc - last_accept_cyc), 2);

        send(18'd100, 5'd2, 1'b1); send(18'd200, 5'd0, 1'b1);
        send(18'd300, 5'd0, 1'b1); send(18'd400, 5'd0, 1'b1);
        drain();
        chk("t2_q", last_q, 250);
        chk("t2_sat", last_sat, 0);

        // Max partials at the shift boundary where clipping starts.
        for (int t = 0; t < 4; t++) send(18'd262143, 5'd12, 1'b1);
        drain();
        chk("t3_acc", last_acc, 1048572);
        chk("t3_q", last_q, 255);
        chk("t3_sat", last_sat, 0);
        for (int t = 0; t < 4; t++) send(18'd262143, 5'd11, 1'b1);
        drain();
        chk("t4_q", last_q, 255);
        chk("t4_sat", last_sat, 1);

        // Sustained streaming: ready never drops.
        pops0 = pops; drops0 = ready_drops;
        for (int i = 0; i < 8 * TILES; i++) begin
            step(1'b1, 1'b1, 18'($urandom_range(262143, 0)), 5'($urandom), 1'b1);
        end
        drain();
        chk("stream_pops", 64'(pops - pops0), 8);
        chk("stream_ready_drops", 64'(ready_drops - drops0), 0);

        // Stall: four buffered groups, fifth stalls only at its last tile.
        pops0 = pops;
        for (int g = 0; g < 4; g++)
            for (int t = 0; t < 4; t++) send(18'(g * 10 + t + 1), 5'd1, 1'b0);
        for (int t = 0; t < 3; t++) send(18'(50 + t), 5'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 18'd53, 5'd0, 1'b0);
            chk("stall_no_accept", 64'(accepted), 0);
        end
        step(1'b1, 1'b1, 18'd53, 5'd0, 1'b1);
        chk("stall_pop_same_cycle", 64'(accepted), 0);
        step(1'b1, 1'b1, 18'd53, 5'd0, 1'b0);
        chk("resume_accept", 64'(accepted), 1);
        drain();
        chk("stall_pops", 64'(pops - pops0), 5);
        chk("stall_last_acc", last_acc, 206);

        // Reset mid-group discards the partial group.
        send(18'd7, 5'd0, 1'b1); send(18'd9, 5'd0, 1'b1);
        step(1'b0, 1'b1, 18'd5, 5'd0, 1'b1);
        for (int t = 1; t <= 4; t++) send(18'(t), 5'd0, 1'b1);
        drain();
        chk("reset_acc", last_acc, 10);

        // Shift sampled only at tile 0, gaps leave the sum intact.
        send(18'd100, 5'd2, 1'b1);
        step(1'b1, 1'b0, 18'd999, 5'd31, 1'b1);
        send(18'd200, 5'd31, 1'b1);
        step(1'b1, 1'b0, 18'd999, 5'd0, 1'b1);
        step(1'b1, 1'b0, 18'd999, 5'd5, 1'b1);
        send(18'd300, 5'd7, 1'b1);
        send(18'd400, 5'd0, 1'b1);
        drain();
        chk("gap_acc", last_acc, 1000);
        chk("gap_q", last_q, 250);

        // Random traffic with gaps and backpressure.
        for (int i = 0; i < 800; i++) begin
            step(1'b1, ($urandom % 4) != 0, 18'($urandom_range(262143, 0)),
                 5'($urandom), ($urandom % 3) != 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
